// File: rtl/can_rx_pack_pkg.sv
// Shared types and constants for the CAN RX byte packer.
//   state_t        : packer FSM states
//   MAX_WORDS_DFLT : default staging depth in 32-bit words
//   WORD_W         : FIFO word width
//   BYTE_LANES     : bytes per FIFO word
//   sat_inc16      : saturating 16-bit increment used by the optional statistics
package can_rx_pack_pkg;

  typedef enum logic [1:0] {IDLE, COLLECT, BURST} state_t;

  localparam int MAX_WORDS_DFLT = 15;
  localparam int WORD_W         = 32;
  localparam int BYTE_LANES     = 4;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/can_rx_pack_buf.sv
// Staging register file for one received frame: MAX_WORDS x 32-bit words,
// byte-lane write enables and a single registered read port.
//   clk      : clock
//   wr_en    : write strobe
//   wr_addr  : word being written
//   wr_be    : byte-lane enables for the write
//   wr_data  : write data (lane l in bits [8l+7:8l])
//   rd_en    : load rd_data with word rd_addr; when low rd_data loads zero
//   rd_addr  : word to read
//   rd_data  : registered read data
// A write and a read of the same word in one cycle returns the new bytes, so a
// frame whose last byte arrives together with frame_end reads back complete.
module can_rx_pack_buf
  import can_rx_pack_pkg::*;
#(
  parameter int MAX_WORDS = MAX_WORDS_DFLT,
  parameter int AW        = 4
) (
  input  logic                  clk,
  input  logic                  wr_en,
  input  logic [AW-1:0]         wr_addr,
  input  logic [BYTE_LANES-1:0] wr_be,
  input  logic [WORD_W-1:0]     wr_data,
  input  logic                  rd_en,
  input  logic [AW-1:0]         rd_addr,
  output logic [WORD_W-1:0]     rd_data
);

  localparam logic [AW-1:0] RD_LIM = AW'(MAX_WORDS);

  logic [WORD_W-1:0] mem [MAX_WORDS];
  logic [WORD_W-1:0] rd_word;

  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int l = 0; l < BYTE_LANES; l++) begin
        if (wr_be[l]) mem[wr_addr][8*l +: 8] <= wr_data[8*l +: 8];
      end
    end
  end

  always_comb begin
    rd_word = '0;
    if (rd_addr < RD_LIM) rd_word = mem[rd_addr];
    if (wr_en && (wr_addr == rd_addr)) begin
      for (int l = 0; l < BYTE_LANES; l++) begin
        if (wr_be[l]) rd_word[8*l +: 8] = wr_data[8*l +: 8];
      end
    end
  end

  // Read stage: idle cycles present zero on the FIFO data bus.
  always_ff @(posedge clk) begin
    rd_data <= rd_en ? rd_word : '0;
  end

endmodule

// File: rtl/can_rx_packer.sv
// CAN RX packer: collects received frame bytes, packs them little-endian into
// 32-bit words and, for a good frame, bursts them to the RX FIFO on
// consecutive cycles. Aborted, rejected or overflowing frames never reach the FIFO.
//   clk, rst (sync, active-low), reset_mode (sync, same effect as rst)
//   frame_start, byte_valid, byte_data[7:0], frame_end, frame_ok, frame_abort : from bit-stream processor
//   fifo_wr, fifo_data[31:0] : FIFO write port (wr contiguous per frame)
//   busy      : collecting or bursting
//   trunc_err : 1-cycle pulse, the cycle after a frame is dropped
// Optional feature macro CAN_RX_PACK_STATS_EN adds good_cnt[15:0] / drop_cnt[15:0]
// saturating counters, cleared by rst only.
module can_rx_packer
  import can_rx_pack_pkg::*;
#(
  parameter int MAX_WORDS = MAX_WORDS_DFLT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              reset_mode,
  input  logic              frame_start,
  input  logic              byte_valid,
  input  logic [7:0]        byte_data,
  input  logic              frame_end,
  input  logic              frame_ok,
  input  logic              frame_abort,
  output logic              fifo_wr,
  output logic [WORD_W-1:0] fifo_data,
  output logic              busy,
  output logic              trunc_err
`ifdef CAN_RX_PACK_STATS_EN
  ,
  output logic [15:0]       good_cnt,
  output logic [15:0]       drop_cnt
`endif
);

  localparam int            CW   = $clog2(MAX_WORDS + 1);
  localparam logic [CW-1:0] FULL = CW'(MAX_WORDS);

  state_t                state, state_nx;
  logic [1:0]            byte_idx, byte_idx_nx;
  logic [CW-1:0]         word_cnt, word_cnt_nx;
  logic [CW-1:0]         n_words, n_words_nx;
  logic [CW-1:0]         rd_idx, rd_idx_nx;
  logic                  drop, drop_nx;
  logic                  trunc_nx;
  logic                  clr;
  logic                  ovf;
  logic [CW-1:0]         words_total;
  logic                  wr_en, rd_en;
  logic [CW-1:0]         rd_addr;
  logic [BYTE_LANES-1:0] wr_be;
  logic [WORD_W-1:0]     wr_data;

  assign clr = !rst || reset_mode;

  always_comb begin
    state_nx    = state;
    byte_idx_nx = byte_idx;
    word_cnt_nx = word_cnt;
    n_words_nx  = n_words;
    rd_idx_nx   = rd_idx;
    drop_nx     = drop;
    trunc_nx    = 1'b0;
    ovf         = 1'b0;
    words_total = '0;
    wr_en       = 1'b0;
    rd_en       = 1'b0;
    rd_addr     = rd_idx;
    // Lane 0 rewrites the whole word with zero upper lanes, so a partial last
    // word is zero-padded without a separate clear of the staging buffer.
    wr_be       = (byte_idx == 2'd0) ? 4'b1111 : (4'b0001 << byte_idx);
    wr_data     = (byte_idx == 2'd0) ? {24'h0, byte_data} : {4{byte_data}};

    case (state)
      IDLE: begin
        if (frame_start) begin
          state_nx    = COLLECT;
          byte_idx_nx = 2'd0;
          word_cnt_nx = '0;
          drop_nx     = 1'b0;
        end
      end

      COLLECT: begin
        ovf   = byte_valid && (word_cnt == FULL);
        wr_en = byte_valid && !ovf && !frame_start && !frame_abort;
        // A byte arriving with frame_end lands in word word_cnt, so it always counts.
        words_total = word_cnt + CW'(wr_en || (byte_idx != 2'd0));
        if (wr_en) begin
          byte_idx_nx = byte_idx + 2'd1;
          if (byte_idx == 2'd3) word_cnt_nx = word_cnt + CW'(1);
        end
        if (ovf) drop_nx = 1'b1;

        if (frame_abort) begin
          state_nx = IDLE;
        end else if (frame_start) begin
          byte_idx_nx = 2'd0;
          word_cnt_nx = '0;
          drop_nx     = 1'b0;
        end else if (frame_end) begin
          state_nx = IDLE;
          if (drop || ovf) begin
            trunc_nx = 1'b1;
          end else if (frame_ok && (words_total != '0)) begin
            // Fetch word 0 now so it is on fifo_data in the first BURST cycle.
            state_nx   = BURST;
            n_words_nx = words_total;
            rd_idx_nx  = CW'(1);
            rd_en      = 1'b1;
            rd_addr    = '0;
          end
        end
      end

      BURST: begin
        trunc_nx = frame_start || byte_valid;
        if (rd_idx == n_words) begin
          state_nx = IDLE;
        end else begin
          rd_en     = 1'b1;
          rd_idx_nx = rd_idx + CW'(1);
        end
      end

      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      state     <= IDLE;
      byte_idx  <= 2'd0;
      word_cnt  <= '0;
      n_words   <= '0;
      rd_idx    <= '0;
      drop      <= 1'b0;
      trunc_err <= 1'b0;
    end else begin
      state     <= state_nx;
      byte_idx  <= byte_idx_nx;
      word_cnt  <= word_cnt_nx;
      n_words   <= n_words_nx;
      rd_idx    <= rd_idx_nx;
      drop      <= drop_nx;
      trunc_err <= trunc_nx;
    end
  end

  can_rx_pack_buf #(
    .MAX_WORDS (MAX_WORDS),
    .AW        (CW)
  ) u_buf (
    .clk     (clk),
    .wr_en   (wr_en),
    .wr_addr (word_cnt),
    .wr_be   (wr_be),
    .wr_data (wr_data),
    .rd_en   (rd_en && !clr),
    .rd_addr (rd_addr),
    .rd_data (fifo_data)
  );

  assign fifo_wr = (state == BURST);
  assign busy    = (state != IDLE);

`ifdef CAN_RX_PACK_STATS_EN
  logic bad_end;
  assign bad_end = (state == COLLECT) && frame_end && !frame_abort && !frame_start &&
                   !frame_ok && !drop && !(byte_valid && (word_cnt == FULL));

  always_ff @(posedge clk) begin
    if (!rst) begin
      good_cnt <= 16'd0;
      drop_cnt <= 16'd0;
    end else if (!reset_mode) begin
      if ((state == COLLECT) && (state_nx == BURST)) good_cnt <= sat_inc16(good_cnt);
      if (trunc_nx || bad_end) drop_cnt <= sat_inc16(drop_cnt);
    end
  end
`endif

endmodule

// File: tb/tb_can_rx_packer.sv
// Bench for can_rx_packer: a byte-queue reference model predicts every output
// each cycle; directed frames pin the model with literal word values.
module tb_can_rx_packer;
  localparam int MAXW = 15;

  logic        clk = 1'b0;
  logic        rst, reset_mode, frame_start, byte_valid, frame_end, frame_ok, frame_abort;
  logic [7:0]  byte_data;
  logic        fifo_wr, busy, trunc_err;
  logic [31:0] fifo_data;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  can_rx_packer dut (
    .clk         (clk),
    .rst         (rst),
    .reset_mode  (reset_mode),
    .frame_start (frame_start),
    .byte_valid  (byte_valid),
    .byte_data   (byte_data),
    .frame_end   (frame_end),
    .frame_ok    (frame_ok),
    .frame_abort (frame_abort),
    .fifo_wr     (fifo_wr),
    .fifo_data   (fifo_data),
    .busy        (busy),
    .trunc_err   (trunc_err)
  );

  // Reference model: bytes of the frame being received, words still to burst.
  bit          m_coll = 0;
  bit          m_drop = 0;
  logic [7:0]  m_bytes[$];
  logic [31:0] m_bq[$];
  logic        exp_wr = 0, exp_busy = 0, exp_trunc = 0, exp_dchk = 0;
  logic [31:0] exp_data = 0;
  bit          chk_en = 0;

  logic [31:0] wlog[$];
  int          tcnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_step();
    logic [31:0] w;
    exp_trunc = 1'b0;
    if (!rst || reset_mode) begin
      m_coll = 0;
      m_drop = 0;
      m_bytes.delete();
      m_bq.delete();
      exp_dchk = 1'b1;
    end else begin
      exp_dchk = 1'b0;
      if (m_bq.size() > 0) begin
        void'(m_bq.pop_front());
        if (frame_start || byte_valid) exp_trunc = 1'b1;
      end else if (m_coll) begin
        if (frame_abort) begin
          m_coll = 0;
        end else if (frame_start) begin
          m_bytes.delete();
          m_drop = 0;
        end else begin
          if (byte_valid) begin
            if (m_bytes.size() == MAXW * 4) m_drop = 1;
            else m_bytes.push_back(byte_data);
          end
          if (frame_end) begin
            m_coll = 0;
            if (m_drop) begin
              exp_trunc = 1'b1;
            end else if (frame_ok && m_bytes.size() > 0) begin
              for (int i = 0; i < m_bytes.size(); i += 4) begin
                w = '0;
                for (int l = 0; l < 4; l++)
                  if (i + l < m_bytes.size()) w[8*l +: 8] = m_bytes[i+l];
                m_bq.push_back(w);
              end
            end
          end
        end
      end else if (frame_start) begin
        m_coll = 1;
        m_bytes.delete();
        m_drop = 0;
      end
    end
    exp_wr   = (m_bq.size() > 0);
    exp_data = exp_wr ? m_bq[0] : 32'h0;
    exp_busy = m_coll || exp_wr;
    chk_en   = 1;
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("fifo_wr", 32'(fifo_wr), 32'(exp_wr));
      chk("busy", 32'(busy), 32'(exp_busy));
      chk("trunc_err", 32'(trunc_err), 32'(exp_trunc));
      if (exp_wr || exp_dchk) chk("fifo_data", fifo_data, exp_data);
      if (fifo_wr === 1'b1) wlog.push_back(fifo_data);
      if (trunc_err === 1'b1) tcnt++;
    end
  end

  task automatic tick(input bit fs, input bit bv, input logic [7:0] bd,
                      input bit fe, input bit fo, input bit fa);
    frame_start = fs;
    byte_valid  = bv;
    byte_data   = bd;
    frame_end   = fe;
    frame_ok    = fo;
    frame_abort = fa;
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) tick(0, 0, 8'h00, 0, 0, 0);
  endtask

  task automatic send(input int n, input logic [7:0] base, input bit ok, input bit end_on_last);
    tick(1, 0, 8'h00, 0, 0, 0);
    for (int k = 0; k < n; k++)
      tick(0, 1, 8'(base + 8'(k)), end_on_last && (k == n - 1), ok, 0);
    if (!(end_on_last && n > 0)) tick(0, 0, 8'h00, 1, ok, 0);
  endtask

  task automatic clr_logs();
    wlog.delete();
    tcnt = 0;
  endtask

  function automatic logic [31:0] wl(input int i);
    return (wlog.size() > i) ? wlog[i] : 32'hDEADBEEF;
  endfunction

  task automatic chk_outputs_zero(input string tag);
    chk({tag, "_fifo_wr"}, 32'(fifo_wr), 32'h0);
    chk({tag, "_fifo_data"}, fifo_data, 32'h0);
    chk({tag, "_busy"}, 32'(busy), 32'h0);
    chk({tag, "_trunc"}, 32'(trunc_err), 32'h0);
  endtask

  int len, r;
  bit ok, lw;

  initial begin
    rst = 1'b0; reset_mode = 1'b0;
    frame_start = 0; byte_valid = 0; byte_data = 0; frame_end = 0; frame_ok = 0; frame_abort = 0;
    idle(3);
    chk_outputs_zero("reset");
    rst = 1'b1;
    idle(2);

    // 13 bytes -> 4 words, last one zero padded
    clr_logs(); send(13, 8'h01, 1, 0); idle(8);
    chk("t1_words", 32'(wlog.size()), 32'd4);
    chk("t1_w0", wl(0), 32'h04030201);
    chk("t1_w1", wl(1), 32'h08070605);
    chk("t1_w2", wl(2), 32'h0C0B0A09);
    chk("t1_w3", wl(3), 32'h0000000D);

    // abort after 6 bytes, then a good 4-byte frame
    clr_logs();
    tick(1, 0, 8'h00, 0, 0, 0);
    for (int k = 0; k < 6; k++) tick(0, 1, 8'(8'h50 + 8'(k)), 0, 0, 0);
    tick(0, 0, 8'h00, 0, 0, 1);
    idle(4);
    chk("t2_abort_words", 32'(wlog.size()), 32'd0);
    clr_logs(); send(4, 8'hA1, 1, 0); idle(4);
    chk("t2_words", 32'(wlog.size()), 32'd1);
    chk("t2_w0", wl(0), 32'hA4A3A2A1);

    // 61 bytes overflow
    clr_logs(); send(61, 8'h01, 1, 0); idle(4);
    chk("t3_trunc", 32'(tcnt), 32'd1);
    chk("t3_words", 32'(wlog.size()), 32'd0);

    // exactly 60 bytes fits
    clr_logs(); send(60, 8'h01, 1, 0); idle(20);
    chk("t3b_words", 32'(wlog.size()), 32'd15);
    chk("t3b_w14", wl(14), 32'h3C3B3A39);
    chk("t3b_trunc", 32'(tcnt), 32'd0);

    // rejected frame
    clr_logs(); send(8, 8'h70, 0, 0); idle(4);
    chk("t4_words", 32'(wlog.size()), 32'd0);
    chk("t4_trunc", 32'(tcnt), 32'd0);

    // frame_start in 3rd burst cycle of a 4-word frame
    clr_logs(); send(16, 8'h10, 1, 0);
    idle(2);
    tick(1, 0, 8'h00, 0, 0, 0);
    idle(6);
    chk("t5_words", 32'(wlog.size()), 32'd4);
    chk("t5_w3", wl(3), 32'h1F1E1D1C);
    chk("t5_trunc", 32'(tcnt), 32'd1);

    // last byte with frame_end
    clr_logs(); send(5, 8'h21, 1, 1); idle(4);
    chk("t6_words", 32'(wlog.size()), 32'd2);
    chk("t6_w0", wl(0), 32'h24232221);
    chk("t6_w1", wl(1), 32'h00000025);

    // empty good frame
    clr_logs(); send(0, 8'h00, 1, 0); idle(3);
    chk("t7_words", 32'(wlog.size()), 32'd0);

    // rst mid-COLLECT
    tick(1, 0, 8'h00, 0, 0, 0);
    for (int k = 0; k < 3; k++) tick(0, 1, 8'h33, 0, 0, 0);
    rst = 1'b0; idle(1);
    chk_outputs_zero("rst_collect");
    rst = 1'b1; idle(2);

    // rst mid-BURST
    send(16, 8'h40, 1, 0); idle(1);
    rst = 1'b0; idle(1);
    chk_outputs_zero("rst_burst");
    rst = 1'b1; idle(2);

    // reset_mode mid-BURST
    send(16, 8'h60, 1, 0); idle(2);
    reset_mode = 1'b1; idle(1);
    chk_outputs_zero("rmode_burst");
    reset_mode = 1'b0; idle(2);

    // randomized frames against the model
    repeat (250) begin
      len = ($urandom_range(0, 9) == 0) ? int'($urandom_range(55, 66)) : int'($urandom_range(0, 20));
      ok  = ($urandom_range(0, 7) != 0);
      lw  = 0;
      tick(1, 0, 8'h00, 0, 0, 0);
      for (int k = 0; k < len; k++) begin
        repeat ($urandom_range(0, 1)) tick(0, 0, 8'($urandom), 0, 0, 0);
        if ($urandom_range(0, 99) == 0) tick(1, 0, 8'h00, 0, 0, 0);
        lw = (k == len - 1) && ($urandom_range(0, 3) == 0);
        tick(0, 1, 8'($urandom), lw, ok, 0);
      end
      if (!lw) begin
        r = int'($urandom_range(0, 29));
        if (r == 0) tick(0, 0, 8'h00, 0, 0, 1);
        else if (r == 1) begin reset_mode = 1'b1; idle(1); reset_mode = 1'b0; end
        else tick(0, 0, 8'($urandom), 1, ok, 0);
      end
      repeat ($urandom_range(0, 18))
        tick($urandom_range(0, 19) == 0, $urandom_range(0, 9) == 0, 8'($urandom), 0, 0, 0);
    end
    idle(20);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
